// File: rtl/bcd_countdown_timer.sv
// -----------------------------------------------------------------------------
// bcd_countdown_timer
//   Three-decade (000-999) loadable BCD down-counter with prescaler, one-cycle
//   done pulse on expiry and optional auto-reload of the last loaded value.
//
// Parameters
//   TICK_DIV     enabled cycles per decrement (1..65535)
//   AUTO_RELOAD  1 = reload last loaded value on expiry and keep running
//
// Ports
//   clk                      system clock, rising edge
//   reset                    synchronous active-high reset
//   load                     1-cycle strobe capturing load_* digits
//   load_ones/tens/hundred   BCD start value
//   enable                   count gate; low freezes digits and prescaler
//   ones/tens/hundred        current BCD value (registered)
//   running                  high while counting
//   done                     1-cycle pulse on expiry
//   load_err                 1-cycle pulse when a load had a digit > 9
// -----------------------------------------------------------------------------
module bcd_countdown_timer #(
  parameter int unsigned TICK_DIV    = 1,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_ones,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_hundred,
  input  logic       enable,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundred,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  localparam int unsigned DW = 4;
  localparam int unsigned PW = 16;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DIGIT_MAX = DW'(9);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [DW-1:0] reload_ones;
  logic [DW-1:0] reload_tens;
  logic [DW-1:0] reload_hundred;

  logic          load_valid_c;
  logic          load_zero_c;
  logic          tick_c;
  logic          at_one_c;
  logic [DW-1:0] dec_ones_c;
  logic [DW-1:0] dec_tens_c;
  logic [DW-1:0] dec_hundred_c;

  // Load qualification: every digit must be a legal BCD value.
  always_comb begin
    load_valid_c = (load_ones <= DIGIT_MAX) && (load_tens <= DIGIT_MAX) &&
                   (load_hundred <= DIGIT_MAX);
    load_zero_c  = (load_ones == '0) && (load_tens == '0) && (load_hundred == '0);
  end

  // Decrement event and the value that triggers expiry.
  always_comb begin
    tick_c   = (state == RUN) && enable && (prescaler == TICK_LAST);
    at_one_c = (ones == DW'(1)) && (tens == '0) && (hundred == '0);
  end

  // Ripple-borrow decrement; only consumed when the value is above 001.
  always_comb begin
    dec_ones_c    = ones - DW'(1);
    dec_tens_c    = tens;
    dec_hundred_c = hundred;
    if (ones == '0) begin
      dec_ones_c = DIGIT_MAX;
      dec_tens_c = tens - DW'(1);
      if (tens == '0) begin
        dec_tens_c    = DIGIT_MAX;
        dec_hundred_c = hundred - DW'(1);
      end
    end
  end

  // State, digits, prescaler, reload register and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      prescaler      <= '0;
      ones           <= '0;
      tens           <= '0;
      hundred        <= '0;
      reload_ones    <= '0;
      reload_tens    <= '0;
      reload_hundred <= '0;
      running        <= 1'b0;
      done           <= 1'b0;
      load_err       <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        // Load beats any tick in the same cycle, so an expiry is suppressed.
        if (load_valid_c) begin
          ones           <= load_ones;
          tens           <= load_tens;
          hundred        <= load_hundred;
          reload_ones    <= load_ones;
          reload_tens    <= load_tens;
          reload_hundred <= load_hundred;
          prescaler      <= '0;
          state          <= load_zero_c ? IDLE : RUN;
          running        <= !load_zero_c;
        end else begin
          load_err <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            if (enable) begin
              if (tick_c) begin
                prescaler <= '0;
                if (at_one_c) begin
                  done <= 1'b1;
                  if (AUTO_RELOAD) begin
                    ones    <= reload_ones;
                    tens    <= reload_tens;
                    hundred <= reload_hundred;
                  end else begin
                    ones    <= '0;
                    tens    <= '0;
                    hundred <= '0;
                    state   <= EXPIRED;
                    running <= 1'b0;
                  end
                end else if ((ones != '0) || (tens != '0) || (hundred != '0)) begin
                  ones    <= dec_ones_c;
                  tens    <= dec_tens_c;
                  hundred <= dec_hundred_c;
                end
              end else begin
                prescaler <= prescaler + PW'(1);
              end
            end
          end
          IDLE, EXPIRED: begin
            // Not armed: ignore enable and keep the prescaler parked.
            prescaler <= '0;
          end
          default: begin
            state     <= IDLE;
            running   <= 1'b0;
            prescaler <= '0;
          end
        endcase
      end
    end
  end

endmodule
